serial_subtractor: RTL and testbench

- Bit-serial unsigned subtractor (diff = a - b): the inverse-direction arithmetic companion to the team's half adder.
- Latches two WIDTH-bit operands on a start pulse, then processes one bit per clock, LSB first, through a registered borrow.
- Returns the difference and final borrow with a one-cycle done pulse.
- Sits beside the adder blocks as a low-area arithmetic unit for the FPGA datapath.

---
 rtl/arith_pkg.sv | 14 +
 rtl/full_subtractor.sv | 24 ++
 rtl/serial_subtractor.sv | 124 ++++++++++++
 tb/tb_serial_subtractor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: sequencer state encoding and default
// operand sizing for the bit-serial arithmetic blocks.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor (x - y - bin) built from two half-subtractor
// stages whose borrows are merged with an OR.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic hs1_d;
    logic hs1_b;
    logic hs2_b;

    // First stage: x - y; second stage: subtract the incoming borrow.
    always_comb begin
        hs1_d = x ^ y;
        hs1_b = ~x & y;
        d     = hs1_d ^ bin;
        hs2_b = ~hs1_d & bin;
        bout  = hs1_b | hs2_b;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: latches a and b on start, retires one
// bit per clock LSB first, and reports a - b with its final borrow.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             br_q, br_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic             bit_d;
    logic             bit_bout;

    full_subtractor u_cell (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (br_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        br_d     = br_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_in) begin
                    state_d = ST_RUN;
                    a_d     = a_in;
                    b_d     = b_in;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d            = a_q >> 1;
                b_d            = b_q >> 1;
                r_d            = r_q >> 1;
                r_d[WIDTH-1]   = bit_d;
                br_d           = bit_bout;
                cnt_d          = cnt_q + CNT_W'(1);
                // The compare uses the pre-increment count, so WIDTH=1 finishes on the first edge.
                if (cnt_q == LAST_CNT) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    diff_d   = r_d;
                    borrow_d = bit_bout;
                end else begin
                    busy_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            br_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            br_q     <= br_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy_out   = busy_q;
    assign done_out   = done_q;
    assign diff_out   = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: vector table at WIDTH=8 plus
// hand-written multi-cycle sequences and a WIDTH=1 instance.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8;
    logic [7:0] a8, b8, diff8;
    logic       busy8, done8, brw8;
    logic       start1;
    logic       a1, b1, diff1;
    logic       busy1, done1, brw1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8), .CNT_W(5)) dut8 (
        .clk_in     (clk),
        .rst_in     (rst),
        .start_in   (start8),
        .a_in       (a8),
        .b_in       (b8),
        .busy_out   (busy8),
        .done_out   (done8),
        .diff_out   (diff8),
        .borrow_out (brw8)
    );

    serial_subtractor #(.WIDTH(1), .CNT_W(1)) dut1 (
        .clk_in     (clk),
        .rst_in     (rst),
        .start_in   (start1),
        .a_in       (a1),
        .b_in       (b1),
        .busy_out   (busy1),
        .done_out   (done1),
        .diff_out   (diff1),
        .borrow_out (brw1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       br;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one WIDTH=8 operation and wait (bounded) for its done pulse.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busy_cnt, output int overlap);
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        lat = 0;
        busy_cnt = 0;
        overlap = 0;
        while (!done8 && lat < 40) begin
            if (busy8) busy_cnt++;
            tick();
            lat++;
        end
        if (busy8 && done8) overlap = 1;
    endtask

    vec_t vecs[9];
    vec_t v1[4];

    initial begin
        int lat, bcnt, ovl, cyc, seen;

        vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
        vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1};
        vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[3] = '{8'h77, 8'h77, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h7F, 8'h01, 1'b0};
        vecs[5] = '{8'h01, 8'hFF, 8'h02, 1'b1};
        vecs[6] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
        vecs[7] = '{8'hA5, 8'h5A, 8'h4B, 1'b0};
        vecs[8] = '{8'h00, 8'h80, 8'h80, 1'b1};

        v1[0] = '{8'h00, 8'h01, 8'h01, 1'b1};
        v1[1] = '{8'h01, 8'h00, 8'h01, 1'b0};
        v1[2] = '{8'h01, 8'h01, 8'h00, 1'b0};
        v1[3] = '{8'h00, 8'h00, 8'h00, 1'b0};

        rst = 1'b1;
        start8 = 1'b0;
        start1 = 1'b0;
        a8 = 8'h00;
        b8 = 8'h00;
        a1 = 1'b0;
        b1 = 1'b0;
        tick();
        tick();
        check("reset8", 32'({busy8, done8, brw8, diff8}), 32'd0);
        check("reset1", 32'({busy1, done1, brw1, diff1}), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            run8(vecs[i].a, vecs[i].b, lat, bcnt, ovl);
            check($sformatf("diff[%0d]", i), 32'(diff8), 32'(vecs[i].d));
            check($sformatf("borrow[%0d]", i), 32'(brw8), 32'(vecs[i].br));
            check($sformatf("latency[%0d]", i), 32'(lat), 32'd8);
            check($sformatf("busy_cycles[%0d]", i), 32'(bcnt), 32'd8);
            check($sformatf("busy_done_overlap[%0d]", i), 32'(ovl), 32'd0);
            tick();
            check($sformatf("done_one_cycle[%0d]", i), 32'(done8), 32'd0);
            check($sformatf("diff_held[%0d]", i), 32'(diff8), 32'(vecs[i].d));
        end

        // start during RUN is ignored
        a8 = 8'hFF;
        b8 = 8'h01;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        check("diff_stable_in_run", 32'(diff8), 32'(vecs[8].d));
        a8 = 8'h00;
        b8 = 8'hFF;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        cyc = 3;
        while (!done8 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("ignore_latency", 32'(cyc), 32'd8);
        check("ignore_diff", 32'(diff8), 32'h0FE);
        check("ignore_borrow", 32'(brw8), 32'd0);
        tick();
        check("ignore_not_queued", 32'(busy8), 32'd0);

        // back-to-back: start held high through DONE
        a8 = 8'h5A;
        b8 = 8'h3C;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        cyc = 0;
        while (cyc < 7) begin
            tick();
            cyc++;
        end
        check("b2b_no_early_done", 32'(done8), 32'd0);
        a8 = 8'h03;
        b8 = 8'h05;
        start8 = 1'b1;
        tick();
        cyc = 8;
        check("b2b_first_done", 32'(done8), 32'd1);
        check("b2b_first_diff", 32'(diff8), 32'h01E);
        tick();
        cyc = 9;
        start8 = 1'b0;
        check("b2b_no_idle", 32'(busy8), 32'd1);
        check("b2b_done_dropped", 32'(done8), 32'd0);
        while (!done8 && cyc < 60) begin
            tick();
            cyc++;
        end
        check("b2b_done_gap", 32'(cyc - 8), 32'd9);
        check("b2b_second_diff", 32'(diff8), 32'h0FE);
        check("b2b_second_borrow", 32'(brw8), 32'd1);
        tick();

        // reset in the middle of RUN
        a8 = 8'h5A;
        b8 = 8'h3C;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_reset_outputs", 32'({busy8, done8, brw8, diff8}), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) seen++;
            tick();
        end
        check("midrun_reset_no_done", 32'(seen), 32'd0);
        run8(8'h09, 8'h04, lat, bcnt, ovl);
        check("after_reset_diff", 32'(diff8), 32'h005);
        check("after_reset_borrow", 32'(brw8), 32'd0);
        check("after_reset_latency", 32'(lat), 32'd8);
        tick();

        // WIDTH=1 instance
        for (int i = 0; i < 4; i++) begin
            a1 = v1[i].a[0];
            b1 = v1[i].b[0];
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            check($sformatf("w1_busy[%0d]", i), 32'(busy1), 32'd1);
            cyc = 0;
            while (!done1 && cyc < 10) begin
                tick();
                cyc++;
            end
            check($sformatf("w1_latency[%0d]", i), 32'(cyc), 32'd1);
            check($sformatf("w1_diff[%0d]", i), 32'(diff1), 32'(v1[i].d[0]));
            check($sformatf("w1_borrow[%0d]", i), 32'(brw1), 32'(v1[i].br));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
